// File: rtl/shift_ctrl_pkg.sv
// rtl/shift_ctrl_pkg.sv - shared encodings for the shift sequencer and logic unit
//
// Purpose: shifter command codes, sequencer state encoding, the op[3]
//          amount-source bit position and the shift-kind legality decode.
// Macro:   SHIFT_CTRL_ROTATE_EN makes rotate kinds (101/110) legal.

package shift_ctrl_pkg;

  // ALU logic-unit op encodings that share this package with the shifter.
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_XOR = 3'b010;
  localparam logic [2:0] ALU_NOR = 3'b011;

  // Shifter (RegDesloc) command codes.
  localparam logic [2:0] CMD_HOLD = 3'b000;
  localparam logic [2:0] CMD_LOAD = 3'b001;
  localparam logic [2:0] CMD_SLL  = 3'b010;
  localparam logic [2:0] CMD_SRL  = 3'b011;
  localparam logic [2:0] CMD_SRA  = 3'b100;
  localparam logic [2:0] CMD_ROR  = 3'b101;
  localparam logic [2:0] CMD_ROL  = 3'b110;

  // Sequencer states.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_ERR   = 3'd4;

  // op[AMT_SRC_BIT]=1 selects the register-sourced amount.
  localparam int AMT_SRC_BIT = 3;

  // A shift kind is legal when the shifter can execute it in this build.
  function automatic logic kind_is_legal(input logic [2:0] kind);
    logic legal;
    legal = (kind == CMD_SLL) || (kind == CMD_SRL) || (kind == CMD_SRA);
`ifdef SHIFT_CTRL_ROTATE_EN
    legal = legal || (kind == CMD_ROR) || (kind == CMD_ROL);
`else
    legal = legal;
`endif
    return legal;
  endfunction

endpackage

// File: rtl/shift_ctrl.sv
// rtl/shift_ctrl.sv - multicycle load-then-shift sequencer for the 32-bit shifter
//
// Purpose: accepts one shift request from the main control unit, drives the
//          shifter through LOAD and SHIFT, then pulses done/result_we.
// Macro:   SHIFT_CTRL_ROTATE_EN enables rotate kinds (see shift_ctrl_pkg).
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   start      request strobe, sampled only in IDLE
//   op         [3] amount source (1=rs_amt, 0=shamt), [2:0] shift kind
//   shamt      immediate amount
//   rs_amt     register amount, low AMT_W bits used
//   src        operand to shift
//   busy       high in every state except IDLE
//   shift_cmd  shifter command (hold/load/kind)
//   shift_n    amount presented to the shifter
//   shift_in   operand presented to the shifter
//   done       one-cycle completion pulse
//   result_we  write enable for the shifter output, coincident with done
//   err        one-cycle pulse for an illegal kind

import shift_ctrl_pkg::*;

module shift_ctrl #(
  parameter int DATA_W = 32,
  parameter int AMT_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [3:0]        op,
  input  logic [AMT_W-1:0]  shamt,
  input  logic [DATA_W-1:0] rs_amt,
  input  logic [DATA_W-1:0] src,
  output logic              busy,
  output logic [2:0]        shift_cmd,
  output logic [AMT_W-1:0]  shift_n,
  output logic [DATA_W-1:0] shift_in,
  output logic              done,
  output logic              result_we,
  output logic              err
);

  logic [2:0]        state_q;
  logic [2:0]        state_d;
  logic [2:0]        kind_q;
  logic [AMT_W-1:0]  amt_q;
  logic [DATA_W-1:0] src_q;
  logic [AMT_W-1:0]  amt_sel;
  logic              capture;

  // Upper rs_amt bits are architecturally ignored (amount truncation).
  logic unused_rs_amt_hi;
  assign unused_rs_amt_hi = ^rs_amt[DATA_W-1:AMT_W];

  assign amt_sel = op[AMT_SRC_BIT] ? rs_amt[AMT_W-1:0] : shamt;
  assign capture = (state_q == ST_IDLE) && start;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = kind_is_legal(op[2:0]) ? ST_LOAD : ST_ERR;
        end
      end
      // A zero amount skips the shift: the loaded value is the result.
      ST_LOAD:  state_d = (amt_q == '0) ? ST_DONE : ST_SHIFT;
      ST_SHIFT: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      ST_ERR:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      kind_q  <= CMD_HOLD;
      amt_q   <= '0;
      src_q   <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        kind_q <= op[2:0];
        amt_q  <= amt_sel;
        src_q  <= src;
      end
    end
  end

  // Moore outputs; shift_in/shift_n are the capture registers and hold
  // until the next accepted request.
  always_comb begin
    busy      = (state_q != ST_IDLE);
    shift_cmd = CMD_HOLD;
    done      = 1'b0;
    result_we = 1'b0;
    err       = 1'b0;
    case (state_q)
      ST_LOAD:  shift_cmd = CMD_LOAD;
      ST_SHIFT: shift_cmd = kind_q;
      ST_DONE: begin
        done      = 1'b1;
        result_we = 1'b1;
      end
      ST_ERR:   err = 1'b1;
      default:  shift_cmd = CMD_HOLD;
    endcase
  end

  assign shift_in = src_q;
  assign shift_n  = amt_q;

endmodule

// File: tb/tb_shift_ctrl.sv
// tb/tb_shift_ctrl.sv - scoreboard bench for shift_ctrl with a behavioural shifter

module tb_shift_ctrl;

`ifdef SHIFT_CTRL_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [4:0]  shamt;
  logic [31:0] rs_amt;
  logic [31:0] src;
  logic        busy;
  logic [2:0]  shift_cmd;
  logic [4:0]  shift_n;
  logic [31:0] shift_in;
  logic        done;
  logic        result_we;
  logic        err;

  shift_ctrl #(.DATA_W(32), .AMT_W(5)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .shamt(shamt),
    .rs_amt(rs_amt), .src(src), .busy(busy), .shift_cmd(shift_cmd),
    .shift_n(shift_n), .shift_in(shift_in), .done(done),
    .result_we(result_we), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  typedef struct {
    bit          is_err;
    int          cyc;
    logic [31:0] result;
    logic [31:0] src;
    logic [4:0]  amt;
  } exp_t;

  exp_t       sb[$];
  logic [2:0] exp_cmd[int];
  bit         exp_busy[int];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  // Expected result of a shift request, from the operation's definition.
  function automatic logic [31:0] ref_shift(input logic [2:0] k, input logic [31:0] v, input int n);
    logic [63:0] d;
    d = {v, v};
    case (k)
      3'd2: return v << n;
      3'd3: return v >> n;
      3'd4: return 32'($signed(v) >>> n);
      3'd5: begin d = d >> n; return d[31:0]; end
      3'd6: begin d = d << n; return d[63:32]; end
      default: return v;
    endcase
  endfunction

  // External shifter (RegDesloc) model driven by the sequencer.
  logic [31:0] sh_reg = '0;
  always @(posedge clk) begin
    case (shift_cmd)
      3'b001: sh_reg <= shift_in;
      3'b010: sh_reg <= sh_reg << shift_n;
      3'b011: sh_reg <= sh_reg >> shift_n;
      3'b100: sh_reg <= $signed(sh_reg) >>> shift_n;
      3'b101: sh_reg <= (sh_reg >> shift_n) | (sh_reg << (32 - int'(shift_n)));
      3'b110: sh_reg <= (sh_reg << shift_n) | (sh_reg >> (32 - int'(shift_n)));
      default: sh_reg <= sh_reg;
    endcase
  end

  // Monitor: per-cycle command/busy trace plus scoreboard for done/err.
  always @(negedge clk) begin
    logic [2:0] ec;
    bit         eb;
    bit         due;
    exp_t       x;
    ec = exp_cmd.exists(cyc) ? exp_cmd[cyc] : 3'b000;
    eb = exp_busy.exists(cyc) ? exp_busy[cyc] : 1'b0;
    chk("shift_cmd", 32'(shift_cmd), 32'(ec));
    chk("busy", 32'(busy), 32'(eb));
    due = (sb.size() > 0) && (sb[0].cyc == cyc);
    if (due) begin
      x = sb.pop_front();
      chk("done", 32'(done), 32'(!x.is_err));
      chk("result_we", 32'(result_we), 32'(!x.is_err));
      chk("err", 32'(err), 32'(x.is_err));
      chk("shift_in_hold", shift_in, x.src);
      chk("shift_n_hold", 32'(shift_n), 32'(x.amt));
      if (!x.is_err) chk("result", sh_reg, x.result);
    end else begin
      chk("done_idle", 32'(done), 32'd0);
      chk("result_we_idle", 32'(result_we), 32'd0);
      chk("err_idle", 32'(err), 32'd0);
    end
  end

  // Issue one request at the current negedge; returns at the first IDLE
  // cycle plus gap cycles. hold_busy keeps start high with junk inputs
  // through every busy cycle, including the done/err cycle.
  task automatic issue(input logic [3:0] op_i, input logic [4:0] shamt_i,
                       input logic [31:0] rs_i, input logic [31:0] src_i,
                       input bit hold_busy, input int gap);
    int         e;
    int         lat;
    bit         legal;
    logic [2:0] k;
    logic [4:0] a;
    exp_t       x;
    k = op_i[2:0];
    a = op_i[3] ? rs_i[4:0] : shamt_i;
    legal = (k == 3'd2) || (k == 3'd3) || (k == 3'd4) ||
            (ROT_EN && ((k == 3'd5) || (k == 3'd6)));
    lat = !legal ? 1 : ((a == 5'd0) ? 2 : 3);
    e = cyc + 1;
    start = 1'b1; op = op_i; shamt = shamt_i; rs_amt = rs_i; src = src_i;
    for (int i = 0; i < lat; i++) exp_busy[e + i] = 1'b1;
    if (legal) begin
      exp_cmd[e] = 3'b001;
      if (a != 5'd0) exp_cmd[e + 1] = k;
    end
    x.is_err = !legal;
    x.cyc    = e + lat - 1;
    x.result = ref_shift(k, src_i, int'(a));
    x.src    = src_i;
    x.amt    = a;
    sb.push_back(x);
    for (int i = 0; i <= lat; i++) begin
      @(negedge clk);
      if (hold_busy && i < lat) begin
        start = 1'b1; op = 4'($urandom); shamt = 5'($urandom);
        rs_amt = $urandom; src = $urandom;
      end else begin
        start = 1'b0;
      end
    end
    repeat (gap) @(negedge clk);
  endtask

  // Start an sll by 3, then pull reset low during the SHIFT cycle.
  task automatic abort_in_shift();
    int e;
    e = cyc + 1;
    start = 1'b1; op = 4'b0010; shamt = 5'd3; src = $urandom;
    exp_busy[e] = 1'b1; exp_busy[e + 1] = 1'b1;
    exp_cmd[e] = 3'b001; exp_cmd[e + 1] = 3'b010;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_cmd", 32'(shift_cmd), 32'd0);
    chk("abort_shift_in", shift_in, 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout expected=finish cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  r_op;
    logic [4:0]  r_sh;
    logic [31:0] r_rs;
    reset = 1'b0; start = 1'b0; op = '0; shamt = '0; rs_amt = '0; src = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmd", 32'(shift_cmd), 32'd0);
    chk("rst_shift_n", 32'(shift_n), 32'd0);
    chk("rst_shift_in", shift_in, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result_we", 32'(result_we), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(negedge clk);

    issue(4'b0010, 5'd4, $urandom, 32'h0000_00F1, 1'b0, 1);
    issue(4'b1100, 5'($urandom), 32'h0000_0024, 32'h8000_0000, 1'b0, 0);
    issue(4'b0011, 5'd0, $urandom, 32'h1234_5678, 1'b0, 1);
    issue(4'b0111, 5'($urandom), $urandom, $urandom, 1'b0, 1);
    issue(4'b0010, 5'd7, $urandom, $urandom, 1'b1, 0);
    abort_in_shift();
    issue(4'b0101, 5'd8, $urandom, 32'h0000_00AB, 1'b0, 1);
    issue(4'b0110, 5'd4, $urandom, 32'hF000_000F, 1'b0, 0);
    issue(4'b1011, 5'd0, 32'd33, $urandom, 1'b0, 0);

    for (int n = 0; n < 80; n++) begin
      r_op = 4'($urandom_range(0, 15));
      r_sh = 5'($urandom);
      r_rs = $urandom;
      if ($urandom_range(0, 7) == 0) begin
        r_sh = 5'd0;
        r_rs = {$urandom_range(0, 1000), 5'd0};
      end
      issue(r_op, r_sh, r_rs, $urandom, 1'($urandom_range(0, 1)),
            $urandom_range(0, 2));
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
